// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the fetch-stage PC sequencer: controller states and default
// sequential PC step.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  localparam int INSTR_BYTES_DEFAULT = 4;

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter with async active-high clear; holds at all-ones.
// One cycle from inc to count; no backpressure.
module fetch_sequencer_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC controller: advance/hold/redirect decisions, imem handshake,
// deferred redirects while a fetch is in flight, and a fetch-bubble counter.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int INSTR_BYTES = INSTR_BYTES_DEFAULT,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              hazard_stall,
  input  logic              mem_stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              imem_req,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_freeze,
  output logic              if_id_freeze,
  output logic              if_id_flush,
  output logic              if_valid,
  output logic [CNT_W-1:0]  bubble_count
);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] redirect_addr;
  logic [ADDR_W-1:0] redirect_addr_nx;
  logic [ADDR_W-1:0] pc_seq;

  assign pc_seq = pc + ADDR_W'(INSTR_BYTES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_RUN;
      redirect_addr <= '0;
    end else begin
      state         <= state_nx;
      redirect_addr <= redirect_addr_nx;
    end
  end

  // Defaults are the "bubble" outputs: PC held, IF/ID flushed, nothing accepted.
  always_comb begin
    state_nx         = state;
    redirect_addr_nx = redirect_addr;
    imem_req         = 1'b0;
    pc_next          = pc_seq;
    pc_freeze        = 1'b1;
    if_id_freeze     = 1'b0;
    if_id_flush      = 1'b1;
    if_valid         = 1'b0;

    if (!rst) begin
      case (state)
        ST_RUN: begin
          imem_req = 1'b1;
          if (mem_stall) begin
            // EXE is frozen too, so any branch it shows will be presented again.
            if_id_freeze = 1'b1;
            if_id_flush  = 1'b0;
          end else if (branch_taken) begin
            if (imem_ready) begin
              pc_next   = branch_addr;
              pc_freeze = 1'b0;
            end else begin
              redirect_addr_nx = branch_addr;
              state_nx         = ST_DRAIN;
            end
          end else if (hazard_stall) begin
            if_id_freeze = 1'b1;
            if_id_flush  = 1'b0;
          end else if (imem_ready) begin
            pc_freeze   = 1'b0;
            if_id_flush = 1'b0;
            if_valid    = 1'b1;
          end
        end

        ST_DRAIN: begin
          // The in-flight fetch must complete even under mem_stall; its data is dropped.
          imem_req = 1'b1;
          if (mem_stall) begin
            if_id_freeze = 1'b1;
            if_id_flush  = 1'b0;
          end else if (branch_taken) begin
            redirect_addr_nx = branch_addr;
          end
          if (imem_ready) begin
            state_nx = ST_REDIRECT;
          end
        end

        ST_REDIRECT: begin
          pc_next = (branch_taken && !mem_stall) ? branch_addr : redirect_addr;
          if (mem_stall) begin
            if_id_freeze = 1'b1;
            if_id_flush  = 1'b0;
          end else begin
            pc_freeze = 1'b0;
            state_nx  = ST_RUN;
          end
        end

        default: begin
          state_nx = ST_RUN;
        end
      endcase
    end
  end

  fetch_sequencer_sat_counter #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (!if_valid),
    .count(bubble_count)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scenario tasks plus a randomized run against a rule-level model of the fetch sequencer.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        hazard_stall;
  logic        mem_stall;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_ready;

  logic        imem_req, pc_freeze, if_id_freeze, if_id_flush, if_valid;
  logic [31:0] pc_next;
  logic [15:0] bubble_count;

  logic        imem_req4, pc_freeze4, if_id_freeze4, if_id_flush4, if_valid4;
  logic [31:0] pc_next4;
  logic [3:0]  bubble_count4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(32), .INSTR_BYTES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pc(pc), .hazard_stall(hazard_stall), .mem_stall(mem_stall),
    .branch_taken(branch_taken), .branch_addr(branch_addr), .imem_req(imem_req),
    .imem_ready(imem_ready), .pc_next(pc_next), .pc_freeze(pc_freeze),
    .if_id_freeze(if_id_freeze), .if_id_flush(if_id_flush), .if_valid(if_valid),
    .bubble_count(bubble_count)
  );

  fetch_sequencer #(.ADDR_W(32), .INSTR_BYTES(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .pc(pc), .hazard_stall(hazard_stall), .mem_stall(mem_stall),
    .branch_taken(branch_taken), .branch_addr(branch_addr), .imem_req(imem_req4),
    .imem_ready(imem_ready), .pc_next(pc_next4), .pc_freeze(pc_freeze4),
    .if_id_freeze(if_id_freeze4), .if_id_flush(if_id_flush4), .if_valid(if_valid4),
    .bubble_count(bubble_count4)
  );

  // Inputs change on the falling edge; outputs are sampled 2 time units later.
  task automatic drive(input logic r, input logic [31:0] p, input logic hs, input logic ms,
                       input logic bt, input logic [31:0] ba, input logic rdy);
    @(negedge clk);
    rst = r; pc = p; hazard_stall = hs; mem_stall = ms;
    branch_taken = bt; branch_addr = ba; imem_ready = rdy;
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc = 32'h40; hazard_stall = 0; mem_stall = 0;
    branch_taken = 0; branch_addr = 0; imem_ready = 0;
    drive(1, 32'h40, 0, 0, 0, 0, 1);
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", imem_req); end n_cmp++;
    if (pc_freeze !== 1'b1) begin n_err++; $display("FAIL rst_pc_freeze got %b want 1", pc_freeze); end n_cmp++;
    if (if_id_flush !== 1'b1) begin n_err++; $display("FAIL rst_flush got %b want 1", if_id_flush); end n_cmp++;
    if (if_id_freeze !== 1'b0) begin n_err++; $display("FAIL rst_ifid_freeze got %b want 0", if_id_freeze); end n_cmp++;
    if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", if_valid); end n_cmp++;
    if (pc_next !== 32'h44) begin n_err++; $display("FAIL rst_pc_next got %h want 44", pc_next); end n_cmp++;
    if (bubble_count !== 16'd0) begin n_err++; $display("FAIL rst_bubble got %0d want 0", bubble_count); end n_cmp++;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'(i * 4), 0, 0, 0, 0, 1);
      if (pc_next !== 32'((i + 1) * 4)) begin n_err++; $display("FAIL seq_pc_next got %h want %h", pc_next, 32'((i + 1) * 4)); end n_cmp++;
      if (if_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid got %b want 1", if_valid); end n_cmp++;
      if (pc_freeze !== 1'b0) begin n_err++; $display("FAIL seq_pc_freeze got %b want 0", pc_freeze); end n_cmp++;
      if (bubble_count !== 16'd0) begin n_err++; $display("FAIL seq_bubble got %0d want 0", bubble_count); end n_cmp++;
    end
  endtask

  task automatic test_branch_wait();
    drive(0, 32'h10, 0, 0, 1, 32'h100, 0);
    if (imem_req !== 1'b1) begin n_err++; $display("FAIL bw0_req got %b want 1", imem_req); end n_cmp++;
    if (pc_freeze !== 1'b1) begin n_err++; $display("FAIL bw0_pc_freeze got %b want 1", pc_freeze); end n_cmp++;
    if (if_id_flush !== 1'b1) begin n_err++; $display("FAIL bw0_flush got %b want 1", if_id_flush); end n_cmp++;
    if (if_valid !== 1'b0) begin n_err++; $display("FAIL bw0_valid got %b want 0", if_valid); end n_cmp++;
    drive(0, 32'h10, 0, 0, 0, 0, 0);
    if (imem_req !== 1'b1) begin n_err++; $display("FAIL bw1_req got %b want 1", imem_req); end n_cmp++;
    if (pc_freeze !== 1'b1) begin n_err++; $display("FAIL bw1_pc_freeze got %b want 1", pc_freeze); end n_cmp++;
    drive(0, 32'h10, 0, 0, 0, 0, 1);
    if (imem_req !== 1'b1) begin n_err++; $display("FAIL bw2_req got %b want 1", imem_req); end n_cmp++;
    if (if_valid !== 1'b0) begin n_err++; $display("FAIL bw2_valid got %b want 0", if_valid); end n_cmp++;
    if (if_id_flush !== 1'b1) begin n_err++; $display("FAIL bw2_flush got %b want 1", if_id_flush); end n_cmp++;
    drive(0, 32'h10, 0, 0, 0, 0, 0);
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL bw3_req got %b want 0", imem_req); end n_cmp++;
    if (pc_next !== 32'h100) begin n_err++; $display("FAIL bw3_pc_next got %h want 100", pc_next); end n_cmp++;
    if (pc_freeze !== 1'b0) begin n_err++; $display("FAIL bw3_pc_freeze got %b want 0", pc_freeze); end n_cmp++;
    if (if_id_flush !== 1'b1) begin n_err++; $display("FAIL bw3_flush got %b want 1", if_id_flush); end n_cmp++;
    drive(0, 32'h100, 0, 0, 0, 0, 1);
    if (imem_req !== 1'b1) begin n_err++; $display("FAIL bw4_req got %b want 1", imem_req); end n_cmp++;
    if (if_valid !== 1'b1) begin n_err++; $display("FAIL bw4_valid got %b want 1", if_valid); end n_cmp++;
    if (pc_next !== 32'h104) begin n_err++; $display("FAIL bw4_pc_next got %h want 104", pc_next); end n_cmp++;
    if (bubble_count !== 16'd4) begin n_err++; $display("FAIL bw4_bubble got %0d want 4", bubble_count); end n_cmp++;
  endtask

  task automatic test_mem_stall_branch();
    for (int i = 0; i < 2; i++) begin
      drive(0, 32'h104, 0, 1, 1, 32'h300, 1);
      if (pc_freeze !== 1'b1) begin n_err++; $display("FAIL ms_pc_freeze got %b want 1", pc_freeze); end n_cmp++;
      if (if_id_freeze !== 1'b1) begin n_err++; $display("FAIL ms_ifid_freeze got %b want 1", if_id_freeze); end n_cmp++;
      if (if_id_flush !== 1'b0) begin n_err++; $display("FAIL ms_flush got %b want 0", if_id_flush); end n_cmp++;
      if (if_valid !== 1'b0) begin n_err++; $display("FAIL ms_valid got %b want 0", if_valid); end n_cmp++;
    end
    drive(0, 32'h104, 0, 0, 1, 32'h300, 1);
    if (pc_next !== 32'h300) begin n_err++; $display("FAIL msb_pc_next got %h want 300", pc_next); end n_cmp++;
    if (pc_freeze !== 1'b0) begin n_err++; $display("FAIL msb_pc_freeze got %b want 0", pc_freeze); end n_cmp++;
    if (if_id_flush !== 1'b1) begin n_err++; $display("FAIL msb_flush got %b want 1", if_id_flush); end n_cmp++;
    drive(0, 32'h300, 0, 0, 0, 0, 1);
    if (if_valid !== 1'b1) begin n_err++; $display("FAIL msr_valid got %b want 1", if_valid); end n_cmp++;
    if (pc_next !== 32'h304) begin n_err++; $display("FAIL msr_pc_next got %h want 304", pc_next); end n_cmp++;
    if (bubble_count !== 16'd7) begin n_err++; $display("FAIL msr_bubble got %0d want 7", bubble_count); end n_cmp++;
  endtask

  task automatic test_hazard();
    drive(0, 32'h20, 1, 0, 0, 0, 1);
    if (imem_req !== 1'b1) begin n_err++; $display("FAIL hz_req got %b want 1", imem_req); end n_cmp++;
    if (pc_freeze !== 1'b1) begin n_err++; $display("FAIL hz_pc_freeze got %b want 1", pc_freeze); end n_cmp++;
    if (if_id_freeze !== 1'b1) begin n_err++; $display("FAIL hz_ifid_freeze got %b want 1", if_id_freeze); end n_cmp++;
    if (if_id_flush !== 1'b0) begin n_err++; $display("FAIL hz_flush got %b want 0", if_id_flush); end n_cmp++;
    if (if_valid !== 1'b0) begin n_err++; $display("FAIL hz_valid got %b want 0", if_valid); end n_cmp++;
    drive(0, 32'h20, 0, 0, 0, 0, 1);
    if (if_valid !== 1'b1) begin n_err++; $display("FAIL hz_refetch_valid got %b want 1", if_valid); end n_cmp++;
    if (pc_next !== 32'h24) begin n_err++; $display("FAIL hz_refetch_pc_next got %h want 24", pc_next); end n_cmp++;
    if (bubble_count !== 16'd8) begin n_err++; $display("FAIL hz_bubble got %0d want 8", bubble_count); end n_cmp++;
  endtask

  task automatic test_wrap_sat();
    drive(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 1);
    if (pc_next !== 32'h0) begin n_err++; $display("FAIL wrap_pc_next got %h want 0", pc_next); end n_cmp++;
    if (if_valid !== 1'b1) begin n_err++; $display("FAIL wrap_valid got %b want 1", if_valid); end n_cmp++;
    for (int k = 0; k <= 20; k++) begin
      drive(0, 32'h0, 0, 0, 0, 0, 0);
      if (k == 5) begin
        if (bubble_count4 !== 4'd13) begin n_err++; $display("FAIL sat_mid got %0d want 13", bubble_count4); end n_cmp++;
      end
    end
    if (pc_freeze !== 1'b1) begin n_err++; $display("FAIL sat_pc_freeze got %b want 1", pc_freeze); end n_cmp++;
    if (bubble_count4 !== 4'd15) begin n_err++; $display("FAIL sat_cnt4 got %0d want 15", bubble_count4); end n_cmp++;
    if (bubble_count !== 16'd28) begin n_err++; $display("FAIL sat_cnt16 got %0d want 28", bubble_count); end n_cmp++;
  endtask

  task automatic test_reset_drain();
    drive(0, 32'h0, 0, 0, 1, 32'h500, 0);
    if (if_id_flush !== 1'b1) begin n_err++; $display("FAIL rd_flush got %b want 1", if_id_flush); end n_cmp++;
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    if (imem_req !== 1'b1) begin n_err++; $display("FAIL rd_drain_req got %b want 1", imem_req); end n_cmp++;
    #1 rst = 1'b1;
    #1;
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL rd_rst_req got %b want 0", imem_req); end n_cmp++;
    if (pc_freeze !== 1'b1) begin n_err++; $display("FAIL rd_rst_pc_freeze got %b want 1", pc_freeze); end n_cmp++;
    if (if_id_flush !== 1'b1) begin n_err++; $display("FAIL rd_rst_flush got %b want 1", if_id_flush); end n_cmp++;
    if (pc_next !== 32'h4) begin n_err++; $display("FAIL rd_rst_pc_next got %h want 4", pc_next); end n_cmp++;
    if (bubble_count !== 16'd0) begin n_err++; $display("FAIL rd_rst_bubble got %0d want 0", bubble_count); end n_cmp++;
    drive(0, 32'h40, 0, 0, 0, 0, 1);
    if (imem_req !== 1'b1) begin n_err++; $display("FAIL rd_post_req got %b want 1", imem_req); end n_cmp++;
    if (if_valid !== 1'b1) begin n_err++; $display("FAIL rd_post_valid got %b want 1", if_valid); end n_cmp++;
    if (pc_next !== 32'h44) begin n_err++; $display("FAIL rd_post_pc_next got %h want 44", pc_next); end n_cmp++;
  endtask

  task automatic test_random();
    // owed: a branch target is pending behind an in-flight fetch; apply: target goes out now
    bit owed = 0, apply = 0;
    logic [31:0] tgt = 0, ppc = 32'hFFFF_FFF0;
    int bub = 0, bub4 = 0;
    logic r, hs, ms, bt, rdy;
    logic [31:0] ba;
    logic e_req, e_pcf, e_fz, e_fl, e_v;
    logic [31:0] e_pcn;
    for (int c = 0; c < 3000; c++) begin
      r   = (c == 0) || ($urandom_range(0, 249) == 0);
      hs  = ($urandom_range(0, 99) < 15);
      ms  = ($urandom_range(0, 99) < 15);
      bt  = ($urandom_range(0, 99) < 20);
      rdy = ($urandom_range(0, 99) < 60);
      ba  = $urandom & 32'hFFFF_FFFC;
      if (r) begin owed = 0; apply = 0; tgt = 0; bub = 0; bub4 = 0; end
      drive(r, ppc, hs, ms, bt, ba, rdy);
      e_req = !r; e_pcn = ppc + 32'd4; e_pcf = 1; e_fz = 0; e_fl = 1; e_v = 0;
      if (!r) begin
        if (apply) begin
          e_req = 0;
          e_pcn = (bt && !ms) ? ba : tgt;
          e_pcf = ms;
          if (!ms) apply = 0;
        end else if (owed) begin
          if (bt && !ms) tgt = ba;
          if (rdy) begin owed = 0; apply = 1; end
        end else if (ms) begin
          e_pcf = 1;
        end else if (bt) begin
          if (rdy) begin e_pcn = ba; e_pcf = 0; end
          else begin tgt = ba; owed = 1; end
        end else if (hs) begin
          e_fz = 1; e_fl = 0;
        end else if (rdy) begin
          e_pcf = 0; e_fl = 0; e_v = 1;
        end
        if (ms) begin e_fz = 1; e_fl = 0; end
      end
      if (imem_req !== e_req) begin n_err++; $display("FAIL rnd_req c=%0d got %b want %b", c, imem_req, e_req); end n_cmp++;
      if (pc_next !== e_pcn) begin n_err++; $display("FAIL rnd_pc_next c=%0d got %h want %h", c, pc_next, e_pcn); end n_cmp++;
      if (pc_freeze !== e_pcf) begin n_err++; $display("FAIL rnd_pc_freeze c=%0d got %b want %b", c, pc_freeze, e_pcf); end n_cmp++;
      if (if_id_freeze !== e_fz) begin n_err++; $display("FAIL rnd_ifid_freeze c=%0d got %b want %b", c, if_id_freeze, e_fz); end n_cmp++;
      if (if_id_flush !== e_fl) begin n_err++; $display("FAIL rnd_flush c=%0d got %b want %b", c, if_id_flush, e_fl); end n_cmp++;
      if (if_valid !== e_v) begin n_err++; $display("FAIL rnd_valid c=%0d got %b want %b", c, if_valid, e_v); end n_cmp++;
      if (bubble_count !== 16'(bub)) begin n_err++; $display("FAIL rnd_bubble c=%0d got %0d want %0d", c, bubble_count, bub); end n_cmp++;
      if (bubble_count4 !== 4'(bub4)) begin n_err++; $display("FAIL rnd_bubble4 c=%0d got %0d want %0d", c, bubble_count4, bub4); end n_cmp++;
      if ({imem_req4, pc_freeze4, if_id_freeze4, if_id_flush4, if_valid4} !== {e_req, e_pcf, e_fz, e_fl, e_v})
        begin n_err++; $display("FAIL rnd_ctl4 c=%0d got %b want %b", c, {imem_req4, pc_freeze4, if_id_freeze4, if_id_flush4, if_valid4}, {e_req, e_pcf, e_fz, e_fl, e_v}); end n_cmp++;
      if (pc_next4 !== e_pcn) begin n_err++; $display("FAIL rnd_pc_next4 c=%0d got %h want %h", c, pc_next4, e_pcn); end n_cmp++;
      if (!r && !e_v) begin
        if (bub < 65535) bub++;
        if (bub4 < 15) bub4++;
      end
      if (!e_pcf) ppc = e_pcn;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_wait();
    test_mem_stall_branch();
    test_hazard();
    test_wrap_sat();
    test_reset_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controller for the fetch stage PC register: each cycle it decides whether the PC advances, holds or is redirected to a branch target. It drives the PC register's next-value and freeze inputs, the IF/ID pipeline register's freeze and flush, and the instruction-memory request. It owns the request/ready handshake with instruction memory, including deferring a redirect while a fetch is still in flight, and keeps a saturating fetch-bubble counter.

## Interface
- ADDR_W, 32, PC and address width
- INSTR_BYTES, 4, PC increment per sequential fetch
- CNT_W, 16, width of bubble counter
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- pc  in  ADDR_W  current PC register output
- hazard_stall  in  1  load-use stall from hazard detection unit
- mem_stall  in  1  data-memory stall; freezes whole pipeline
- branch_taken  in  1  taken branch resolved in EXE
- branch_addr  in  ADDR_W  branch target, valid with branch_taken
- imem_req  out  1  fetch request at address pc
- imem_ready  in  1  fetch data valid this cycle (may be same cycle as req)
- pc_next  out  ADDR_W  to PC register data input
- pc_freeze  out  1  to PC register freeze input
- if_id_freeze  out  1  hold IF/ID register
- if_id_flush  out  1  clear IF/ID register to bubble
- if_valid  out  1  fetched instruction is accepted into IF/ID this cycle
- bubble_count  out  CNT_W  saturating count of cycles with if_valid=0 outside reset

## Operation
- States: RUN, DRAIN, REDIRECT. Registers: state, redirect_addr, bubble_count.
- Handshake: once imem_req=1 with imem_ready=0, imem_req stays 1 at the same pc until imem_ready; a fetch is never cancelled.
- Priority in all states: mem_stall > branch_taken > hazard_stall > imem wait.
- RUN, imem_req=1:
  - mem_stall: pc_freeze=1, if_id_freeze=1, if_valid=0; branch_taken ignored (EXE is frozen and re-presents it).
  - branch_taken & imem_ready: pc_next=branch_addr, pc_freeze=0, if_id_flush=1, if_valid=0; stay RUN.
  - branch_taken & !imem_ready: redirect_addr<=branch_addr, pc_freeze=1, if_id_flush=1, if_valid=0; go DRAIN.
  - hazard_stall: pc_freeze=1, if_id_freeze=1, if_valid=0; fetch data dropped, same pc refetched next cycle.
  - imem_ready: pc_next=pc+INSTR_BYTES (mod 2^ADDR_W, wraps), pc_freeze=0, if_valid=1.
  - otherwise: pc_freeze=1, if_id_flush=1, if_valid=0.
- DRAIN: imem_req=1, pc_freeze=1, if_id_flush=1, if_valid=0. A new branch_taken (without mem_stall) overwrites redirect_addr. When imem_ready, data is discarded and the state goes to REDIRECT.
- REDIRECT: imem_req=0, if_id_flush=1, if_valid=0, pc_next=redirect_addr.
  - pc_freeze=mem_stall; stays in REDIRECT while mem_stall.
  - Otherwise goes to RUN.
  - branch_taken without mem_stall overwrites the target: pc_next=branch_addr.
- pc_next defaults to pc+INSTR_BYTES whenever not otherwise specified.
- if_id_flush and if_id_freeze are never both 1; freeze wins under mem_stall.
- bubble_count increments on every cycle with if_valid=0 and rst=0, and saturates at all-ones.

## Timing
- Reset (async, rst=1): state=RUN, redirect_addr=0, bubble_count=0.
  - While rst is high: imem_req=0, pc_freeze=1, if_id_flush=1, if_id_freeze=0, if_valid=0, pc_next=pc+INSTR_BYTES.
- Reset mid-DRAIN abandons the outstanding fetch; memory is reset by the same rst.
- All outputs except bubble_count are combinational from state, registers and inputs; there is no added latency.
- Zero-wait memory gives one instruction per cycle; a redirect with zero-wait memory costs 0 extra cycles beyond the flush.
- A branch during an N-cycle wait costs N remaining wait cycles plus 1 REDIRECT cycle.

## Structure
- Shared package: state enum (RUN/DRAIN/REDIRECT), INSTR_BYTES default.
- No sub-module required. The bubble counter may be a separate saturating_counter sub-module.

## Test plan
- **Sequential fetch:** reset at pc=0, imem_ready tied 1 → pc_next=4,8,12; if_valid=1 every cycle; bubble_count=0.
- **Branch during wait:** 3-cycle wait at pc=0x10; branch_taken with 0x100 in the first wait cycle → DRAIN for 2 cycles, then REDIRECT with pc_next=0x100 and pc_freeze=0, then RUN fetching 0x100; bubble_count=4.
- **mem_stall over branch:** mem_stall=1 with branch_taken=1 for 2 cycles → pc_freeze=1 and no flush; the branch then redirects to its target in the cycle after mem_stall drops.
- **Hazard stall:** hazard_stall for 1 cycle at pc=0x20 → pc_freeze=1, if_id_freeze=1; next cycle refetches 0x20.
- **Wrap and saturation:** pc=0xFFFFFFFC gives pc_next=0. With CNT_W=4 and 20 bubble cycles → bubble_count=15.
- **Reset mid-DRAIN:** assert rst → outputs take their reset values immediately; after release the state is RUN and imem_req=1.
